// File: rtl/inst_enc_pkg.sv
// Shared opcode constants, instruction format enum and range helper for inst_encoder.
// Range checking is enabled by defining IMM_RANGE_CHECK_EN.
package inst_enc_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] LI_LUI_OP  = OP_LUI;
  localparam logic [6:0] LI_ADDI_OP = OP_IMM;

`ifdef IMM_RANGE_CHECK_EN
  localparam bit RANGE_CHECK_EN = 1'b1;
`else
  localparam bit RANGE_CHECK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_CSR, FMT_BAD
  } inst_fmt_e;

  function automatic inst_fmt_e opcode_fmt(input logic [6:0] op);
    inst_fmt_e f;
    case (op)
      OP_IMM, OP_JALR, OP_LOAD: f = FMT_I;
      OP_STORE:                 f = FMT_S;
      OP_BRANCH:                f = FMT_B;
      OP_LUI, OP_AUIPC:         f = FMT_U;
      OP_JAL:                   f = FMT_J;
      OP_SYSTEM:                f = FMT_CSR;
      OP_REG:                   f = FMT_R;
      default:                  f = FMT_BAD;
    endcase
    return f;
  endfunction

  // True when v is representable as a signed value whose sign bit is at position msb.
  function automatic logic fits_signed(input logic [31:0] v, input logic [4:0] msb);
    logic signed [31:0] s;
    s = $signed(v) >>> msb;
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Request/response bundle for inst_encoder; slave modport is the encoder side.
interface inst_encoder_if #(parameter int unsigned ERR_CNT_W = 16);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_li;
  logic [6:0]           in_opcode;
  logic [4:0]           in_rd;
  logic [4:0]           in_rs1;
  logic [4:0]           in_rs2;
  logic [2:0]           in_funct3;
  logic [6:0]           in_funct7;
  logic [31:0]          in_imm;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_inst;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_li, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_inst, out_err, err_count
  );

  modport slave (
    input  in_valid, in_li, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_inst, out_err, err_count
  );
endinterface

// File: rtl/inst_field_pack.sv
// Combinational placement of decoded fields and immediate into an RV32I word,
// with immediate range checking (active only when IMM_RANGE_CHECK_EN is defined).
module inst_field_pack
  import inst_enc_pkg::*;
(
  input  inst_fmt_e   fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        range_err
);

  logic err_raw;

  always_comb begin
    inst    = {funct7, rs2, rs1, funct3, rd, opcode};
    err_raw = 1'b0;
    case (fmt)
      FMT_I: begin
        inst[31:20] = imm[11:0];
        err_raw     = !fits_signed(imm, 5'd11);
      end
      FMT_S: begin
        inst[31:25] = imm[11:5];
        inst[11:7]  = imm[4:0];
        err_raw     = !fits_signed(imm, 5'd11);
      end
      FMT_B: begin
        inst[31]    = imm[12];
        inst[30:25] = imm[10:5];
        inst[11:8]  = imm[4:1];
        inst[7]     = imm[11];
        err_raw     = !fits_signed(imm, 5'd12) || imm[0];
      end
      FMT_U: begin
        inst[31:12] = imm[31:12];
        err_raw     = |imm[11:0];
      end
      FMT_J: begin
        inst[31]    = imm[20];
        inst[30:21] = imm[10:1];
        inst[20]    = imm[11];
        inst[19:12] = imm[19:12];
        err_raw     = !fits_signed(imm, 5'd20) || imm[0];
      end
      FMT_CSR: begin
        // funct7/rs2 already sit in [31:20]; only the uimm form replaces rs1
        if (funct3[2]) begin
          inst[19:15] = imm[4:0];
          err_raw     = |imm[31:5];
        end
      end
      FMT_BAD: err_raw = 1'b1;
      default: err_raw = 1'b0;
    endcase
  end

  assign range_err = RANGE_CHECK_EN && err_raw;

endmodule

// File: rtl/inst_encoder.sv
// Pipelined RV32I encoder with LI pseudo-op expansion, one-word output register
// and saturating error counter (counter active when IMM_RANGE_CHECK_EN is defined).
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 16
) (
  input logic           clk,
  input logic           rst,
  inst_encoder_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LI2  = 1'b1;

  logic [0:0]  state;
  logic        valid_q;
  logic [31:0] inst_q;
  logic        err_q;
  logic [4:0]  li_rd;
  logic [11:0] li_lo;

  logic        out_free;
  logic        accept;
  logic        load;
  logic        li_small;
  logic        li_two;
  logic [31:0] li_sum;

  inst_fmt_e   p_fmt;
  logic [6:0]  p_op;
  logic [4:0]  p_rd, p_rs1, p_rs2;
  logic [2:0]  p_f3;
  logic [6:0]  p_f7;
  logic [31:0] p_imm;
  logic        li_word;
  logic [31:0] pack_inst;
  logic        pack_err;

  assign out_free     = !valid_q || bus.out_ready;
  assign bus.in_ready = (state == ST_IDLE) && out_free;
  assign accept       = bus.in_valid && bus.in_ready;
  assign load         = (state == ST_LI2) ? out_free : accept;

  assign li_small = fits_signed(bus.in_imm, 5'd11);
  assign li_sum   = bus.in_imm + 32'h0000_0800;
  assign li_two   = bus.in_li && !li_small && (bus.in_imm[11:0] != '0);

  // The packer is shared: LI words are steered through it as ordinary ADDI/LUI requests.
  always_comb begin
    p_fmt   = opcode_fmt(bus.in_opcode);
    p_op    = bus.in_opcode;
    p_rd    = bus.in_rd;
    p_rs1   = bus.in_rs1;
    p_rs2   = bus.in_rs2;
    p_f3    = bus.in_funct3;
    p_f7    = bus.in_funct7;
    p_imm   = bus.in_imm;
    li_word = 1'b0;
    if (state == ST_LI2) begin
      p_fmt   = FMT_I;
      p_op    = LI_ADDI_OP;
      p_rd    = li_rd;
      p_rs1   = li_rd;
      p_rs2   = '0;
      p_f3    = '0;
      p_f7    = '0;
      p_imm   = {{20{li_lo[11]}}, li_lo};
      li_word = 1'b1;
    end else if (bus.in_li) begin
      p_rs1   = '0;
      p_rs2   = '0;
      p_f3    = '0;
      p_f7    = '0;
      li_word = 1'b1;
      if (li_small) begin
        p_fmt = FMT_I;
        p_op  = LI_ADDI_OP;
      end else begin
        p_fmt = FMT_U;
        p_op  = LI_LUI_OP;
        p_imm = li_sum & 32'hFFFF_F000;
      end
    end
  end

  inst_field_pack u_pack (
    .fmt      (p_fmt),
    .opcode   (p_op),
    .rd       (p_rd),
    .rs1      (p_rs1),
    .rs2      (p_rs2),
    .funct3   (p_f3),
    .funct7   (p_f7),
    .imm      (p_imm),
    .inst     (pack_inst),
    .range_err(pack_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      valid_q <= 1'b0;
      inst_q  <= '0;
      err_q   <= 1'b0;
      li_rd   <= '0;
      li_lo   <= '0;
    end else begin
      if (load) begin
        valid_q <= 1'b1;
        inst_q  <= pack_inst;
        err_q   <= pack_err && !li_word;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
      case (state)
        ST_IDLE: if (accept && li_two) begin
          state <= ST_LI2;
          li_rd <= bus.in_rd;
          li_lo <= bus.in_imm[11:0];
        end
        ST_LI2:  if (load) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_inst  = inst_q;
  assign bus.out_err   = err_q;

`ifdef IMM_RANGE_CHECK_EN
  logic [ERR_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (valid_q && bus.out_ready && err_q && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.err_count = cnt_q;
`else
  assign bus.err_count = '0;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized self-checking bench for inst_encoder against a queue-based reference model.
module tb_inst_encoder;

`ifdef IMM_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   rand_rdy = 1'b0;
  bit   rdy_hold = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t        q[$];
  logic [31:0] log_q[$];
  logic [15:0] exp_cnt = '0;
  bit          stall_prev = 1'b0;
  logic [31:0] held_inst = '0;

  inst_encoder_if #(.ERR_CNT_W(16)) bus ();

  inst_encoder #(.ERR_CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic void push_exp(input logic [31:0] w, input bit e);
    exp_t x;
    x.inst = w;
    x.err  = e;
    q.push_back(x);
  endfunction

  // Reference: expected words straight from the placement and range rules.
  function automatic void model_push(input bit li, input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [31:0] imm);
    int signed   s;
    logic [31:0] w, hi, lo;
    bit          e;
    s = $signed(imm);
    if (li) begin
      if (s >= -2048 && s <= 2047) begin
        push_exp(((imm & 32'hFFF) << 20) | (32'(rd) << 7) | 32'h13, 1'b0);
      end else begin
        hi = (imm + 32'h800) >> 12;
        lo = imm & 32'hFFF;
        push_exp((hi << 12) | (32'(rd) << 7) | 32'h37, 1'b0);
        if (lo != 0) push_exp((lo << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13, 1'b0);
      end
    end else begin
      w = (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) |
          (32'(rd) << 7) | 32'(op);
      e = 1'b0;
      case (op)
        7'h13, 7'h67, 7'h03: begin
          w = (w & 32'h000FFFFF) | ((imm & 32'hFFF) << 20);
          e = (s < -2048) || (s > 2047);
        end
        7'h23: begin
          w = (w & 32'h01FFF07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
          e = (s < -2048) || (s > 2047);
        end
        7'h63: begin
          w = (w & 32'h01FFF07F) | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
              (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
          e = (s < -4096) || (s > 4095) || ((imm & 32'h1) != 0);
        end
        7'h37, 7'h17: begin
          w = (w & 32'hFFF) | (imm & 32'hFFFFF000);
          e = (imm & 32'hFFF) != 0;
        end
        7'h6F: begin
          w = (w & 32'hFFF) | (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
              (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12);
          e = (s < -1048576) || (s > 1048575) || ((imm & 32'h1) != 0);
        end
        7'h73: begin
          if (f3[2]) begin
            w = (w & ~(32'h1F << 15)) | ((imm & 32'h1F) << 15);
            e = imm > 32'd31;
          end
        end
        7'h33: e = 1'b0;
        default: e = 1'b1;
      endcase
      push_exp(w, e && CHK);
    end
  endfunction

  always @(posedge clk) begin
    #2;
    bus.out_ready = rand_rdy ? ($urandom_range(0, 9) < 7) : rdy_hold;
  end

  // Monitor: one sample per cycle at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_cnt    = '0;
      stall_prev = 1'b0;
    end else begin
      check("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
      check("in_ready", 64'(bus.in_ready), 64'(q.size() == 0 || (q.size() == 1 && bus.out_ready)));
      check("err_count", 64'(bus.err_count), 64'(exp_cnt));
      if (stall_prev) check("hold_inst", 64'(bus.out_inst), 64'(held_inst));
      if (bus.out_valid && q.size() != 0) begin
        check("out_inst", 64'(bus.out_inst), 64'(q[0].inst));
        check("out_err", 64'(bus.out_err), 64'(q[0].err));
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held_inst  = bus.out_inst;
      if (bus.out_valid && bus.out_ready && q.size() != 0) begin
        log_q.push_back(bus.out_inst);
        if (q[0].err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        void'(q.pop_front());
      end
      if (bus.in_valid && bus.in_ready)
        model_push(bus.in_li, bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2,
                   bus.in_funct3, bus.in_funct7, bus.in_imm);
    end
  end

  task automatic drive(input bit li, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    bus.in_valid  = 1'b1;
    bus.in_li     = li;
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
  endtask

  task automatic wait_accept();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      check("accept_timeout", 64'd0, 64'd1);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic send(input bit li, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    drive(li, op, rd, rs1, rs2, f3, f7, imm);
    wait_accept();
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0]  ops [0:10];
    int          base;
    logic [15:0] cnt0;
    logic [31:0] imm;
    ops = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h7F};

    drive(1'b0, 7'h33, '0, '0, '0, '0, '0, '0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_inst", 64'(bus.out_inst), 64'd0);
    check("rst_out_err", 64'(bus.out_err), 64'd0);
    check("rst_err_count", 64'(bus.err_count), 64'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Branch with negative offset
    base = log_q.size();
    send(1'b0, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
    drain();
    check("b_word", 64'(log_q[base]), 64'hFE208EE3);

    // Two-word LI
    base = log_q.size();
    send(1'b1, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
    @(negedge clk);
    check("li2_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    drain();
    check("li_lui", 64'(log_q[base]), 64'h123462B7);
    check("li_addi", 64'(log_q[base+1]), 64'hFFF28293);

    // Single-word LI forms
    base = log_q.size();
    send(1'b1, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0001_2000);
    drain();
    check("li_lui_only", 64'(log_q[base]), 64'h000122B7);
    check("li_lui_count", 64'(log_q.size() - base), 64'd1);
    base = log_q.size();
    send(1'b1, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
    drain();
    check("li_addi_only", 64'(log_q[base]), 64'h80000293);
    check("li_addi_count", 64'(log_q.size() - base), 64'd1);

    // Out-of-range I immediate
    base = log_q.size();
    cnt0 = bus.err_count;
    send(1'b0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
    drain();
    check("i_range_word", 64'(log_q[base]), 64'h80000093);
    check("i_range_cnt", 64'(bus.err_count), 64'(cnt0) + 64'(CHK));

    // Output stall: hold for 3 cycles, then resume back-to-back
    rdy_hold = 1'b0;
    @(posedge clk);
    #1;
    base = log_q.size();
    send(1'b0, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0);
    drive(1'b0, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_inst", 64'(bus.out_inst), 64'h405201B3);
      check("stall_ready", 64'(bus.in_ready), 64'd0);
    end
    rdy_hold = 1'b1;
    wait_accept();
    drain();
    check("resume_w0", 64'(log_q[base]), 64'h405201B3);
    check("resume_w1", 64'(log_q[base+1]), 64'h00500313);

    // Reset while the ADDI of a two-word LI is pending
    rdy_hold = 1'b0;
    @(posedge clk);
    #1;
    send(1'b1, 7'h00, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_li2_valid", 64'(bus.out_valid), 64'd0);
    check("rst_li2_idle", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    rdy_hold = 1'b1;
    base = log_q.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_addi_after_rst", 64'(bus.out_valid), 64'd0);
    end
    check("no_words_after_rst", 64'(log_q.size() - base), 64'd0);
    @(posedge clk);
    #1;

    // Randomized traffic with random back-pressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        1:       imm = $urandom;
        2:       imm = $urandom & 32'hFFFF_F000;
        3:       imm = 32'($urandom_range(0, 40));
        default: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      endcase
      send($urandom_range(0, 4) == 0, ops[$urandom_range(0, 10)], 5'($urandom),
           5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm);
    end
    rand_rdy = 1'b0;
    rdy_hold = 1'b1;
    @(posedge clk);
    #1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
